// File: rtl/rv32i_bus_decoder.sv
// Core data-port decoder: base/size region decode, posted writes, 2+ cycle reads with timeout, registered error/valid pulses.
// Master holds its request while m_busy_o is high; optional faulting-address capture under BUS_ERR_CAPTURE_EN.
module rv32i_bus_decoder #(
  parameter int NSLAVES = 2,
  parameter logic [NSLAVES-1:0][31:0] SLAVE_BASE = {32'h0001_0000, 32'h0000_0000},
  parameter logic [NSLAVES-1:0][31:0] SLAVE_SIZE = {32'd4096, 32'd4096},
  parameter int TIMEOUT = 15
) (
  input  logic                   clk_i,
  input  logic                   resetn_i,
  input  logic [31:0]            m_add_i,
  input  logic                   m_re_i,
  input  logic                   m_we_i,
  input  logic [3:0]             m_ble_i,
  input  logic [31:0]            m_di_i,
  output logic [31:0]            m_do_o,
  output logic                   m_valid_o,
  output logic                   m_err_o,
  output logic                   m_busy_o,
  output logic [31:0]            err_add_o,
  output logic [31:0]            s_add_o,
  output logic [31:0]            s_di_o,
  output logic [3:0]             s_ble_o,
  output logic [NSLAVES-1:0]     s_re_o,
  output logic [NSLAVES-1:0]     s_we_o,
  input  logic [NSLAVES*32-1:0]  s_do_i,
  input  logic [NSLAVES-1:0]     s_valid_i
);

  localparam int IW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

  typedef enum logic {IDLE, WAIT_RD} state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   hit_idx;
  logic            hit_any;
  logic [31:0]     do_d;
  logic            valid_d, err_d;
  logic [31:0]     s_rd [NSLAVES];

  assign s_add_o = m_add_i;
  assign s_di_o  = m_di_i;
  assign s_ble_o = m_ble_i;

  // 33-bit compare so a region ending exactly at 2^32 does not wrap; lowest index wins on overlap.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int k = NSLAVES - 1; k >= 0; k--) begin
      if (({1'b0, m_add_i} >= {1'b0, SLAVE_BASE[k]}) &&
          ({1'b0, m_add_i} <  ({1'b0, SLAVE_BASE[k]} + {1'b0, SLAVE_SIZE[k]}))) begin
        hit_any = 1'b1;
        hit_idx = IW'(k);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NSLAVES; k++) begin
      s_rd[k] = s_do_i[k*32 +: 32];
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      m_do_o    <= '0;
      m_valid_o <= 1'b0;
      m_err_o   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      m_do_o    <= do_d;
      m_valid_o <= valid_d;
      m_err_o   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    do_d     = m_do_o;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    s_re_o   = '0;
    s_we_o   = '0;
    m_busy_o = 1'b0;
    case (state_q)
      IDLE: begin
        // Strobes are gated by reset so nothing leaks to slaves while held in reset.
        if (resetn_i) begin
          if (m_re_i && m_we_i) begin
            err_d = 1'b1;
          end else if (m_re_i) begin
            if (hit_any) begin
              s_re_o[hit_idx] = 1'b1;
              idx_d    = hit_idx;
              cnt_d    = '0;
              state_d  = WAIT_RD;
              m_busy_o = 1'b1;
            end else begin
              err_d   = 1'b1;
              valid_d = 1'b1;
              do_d    = '0;
            end
          end else if (m_we_i) begin
            if (hit_any) s_we_o[hit_idx] = 1'b1;
            else         err_d = 1'b1;
          end
        end
      end
      WAIT_RD: begin
        m_busy_o = 1'b1;
        if (s_valid_i[idx_q]) begin
          do_d    = s_rd[idx_q];
          valid_d = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          do_d    = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef BUS_ERR_CAPTURE_EN
  logic [31:0] req_add_q, err_add_q;

  // Timeouts report the address of the read that was issued, not whatever the master drives now.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      req_add_q <= '0;
      err_add_q <= '0;
    end else begin
      if (state_q == IDLE && |s_re_o) req_add_q <= m_add_i;
      if (err_d) err_add_q <= (state_q == WAIT_RD) ? req_add_q : m_add_i;
    end
  end

  assign err_add_o = err_add_q;
`else
  assign err_add_o = '0;
`endif

endmodule
